frame_tx_sequencer: RTL

Sequences one frame at a time into the whitening stage of the framing/encoding transmit chain. It accepts payload bytes from an upstream valid/ready byte stream and issues the start pulse on `wh_ind`. It then presents 8 preamble bytes, a 2-byte sync word and the payload on `wh_din`, one byte per 8-cycle slot, and closes the frame with an end pulse. It waits for the chain's completion pulse before accepting the next frame, and reports underrun, timeout and frame length.

---
 rtl/framing_pkg.sv | 22 ++
 rtl/frame_tx_sequencer_if.sv | 10 +
 rtl/frame_tx_sequencer_slot_timer.sv | 34 +++
 rtl/frame_tx_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/framing_pkg.sv
// Shared types and framing constants for the transmit sequencer.
package framing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_PAYLOAD,
    ST_WAIT_DONE
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam int         PREAMBLE_LEN  = 8;
  localparam int         SLOT_LEN      = 8;
  // Must match the whitener's pad length / 8.
  localparam int         HEADER_SLOTS  = 10;
  localparam int         SLOT_CNT_W    = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tx_sequencer_if.sv
// Upstream valid/ready payload byte stream.
interface frame_tx_sequencer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input  s_ready);
  modport slave  (input  s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/frame_tx_sequencer_slot_timer.sv
// Byte-slot timebase: phase counts within a slot, slot counts slots since clr.
module slot_timer
  import framing_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  output logic [SLOT_CNT_W-1:0] slot,
  output logic                  sample
);
  localparam int PW = $clog2(SLOT_LEN);

  logic [PW-1:0] phase;
  logic          wrap;

  assign wrap = (phase == PW'(SLOT_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      slot  <= '0;
    end else if (clr) begin
      phase <= '0;
      slot  <= '0;
    end else begin
      phase <= wrap ? '0 : phase + PW'(1);
      // Saturate so long payloads keep producing samples.
      if (wrap && slot != '1) slot <= slot + SLOT_CNT_W'(1);
    end
  end

  assign sample = (phase == '0) && (slot != '0);

endmodule

// File: rtl/frame_tx_sequencer.sv
// Frame sequencer: preamble, sync word and payload into the whitener, one byte per slot.
module frame_tx_sequencer
  import framing_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD    = 16'hD391,
  parameter int          DONE_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  frame_tx_sequencer_if.slave  s,
  output logic [7:0]           wh_din,
  output logic                 wh_ind,
  input  logic                 wh_next_ind,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_len,
  output logic                 underrun,
  output logic                 timeout_err
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  state_t          state, state_n;
  logic [7:0]      hold_data, hold_data_n;
  logic            hold_valid, hold_valid_n;
  logic            hold_last, hold_last_n;
  logic            last_taken, last_taken_n;
  logic            din_last, din_last_n;
  logic [7:0]      wh_din_n, frame_len_n;
  logic            wh_ind_n, frame_done_n, underrun_n, timeout_err_n;
  logic [TW-1:0]   wait_cnt, wait_cnt_n;
  logic [SLOT_CNT_W-1:0] slot;
  logic            sample, start, s_fire, load_payload, go_idle;

  assign s.s_ready = !hold_valid && !last_taken && (state != ST_WAIT_DONE);
  assign s_fire    = s.s_valid && s.s_ready;
  assign busy      = (state != ST_IDLE);
  // A byte accepted in IDLE launches the frame on the same edge.
  assign start     = (state == ST_IDLE) && (hold_valid || s_fire);

  slot_timer u_slot_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .slot    (slot),
    .sample  (sample)
  );

  always_comb begin
    state_n       = state;
    hold_data_n   = hold_data;
    hold_valid_n  = hold_valid;
    hold_last_n   = hold_last;
    last_taken_n  = last_taken;
    din_last_n    = din_last;
    wh_din_n      = wh_din;
    wh_ind_n      = 1'b0;
    frame_done_n  = 1'b0;
    frame_len_n   = frame_len;
    underrun_n    = underrun;
    timeout_err_n = timeout_err;
    wait_cnt_n    = wait_cnt;
    load_payload  = 1'b0;
    go_idle       = 1'b0;

    if (s_fire) begin
      hold_valid_n = 1'b1;
      hold_data_n  = s.s_data;
      hold_last_n  = s.s_last;
      if (s.s_last) last_taken_n = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n       = ST_PRE;
          wh_ind_n      = 1'b1;
          wh_din_n      = PREAMBLE_BYTE;
          din_last_n    = 1'b0;
          underrun_n    = 1'b0;
          timeout_err_n = 1'b0;
          frame_len_n   = 8'h00;
        end
      end
      ST_PRE: begin
        if (sample) begin
          if (slot == SLOT_CNT_W'(PREAMBLE_LEN))
            wh_din_n = SYNC_WORD[15:8];
          else if (slot == SLOT_CNT_W'(PREAMBLE_LEN + 1))
            wh_din_n = SYNC_WORD[7:0];
          else if (slot == SLOT_CNT_W'(HEADER_SLOTS)) begin
            load_payload = 1'b1;
            state_n      = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (sample) begin
          if (din_last) begin
            wh_ind_n   = 1'b1;
            state_n    = ST_WAIT_DONE;
            wait_cnt_n = '0;
          end else begin
            load_payload = 1'b1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (wh_next_ind) begin
          frame_done_n = 1'b1;
          go_idle      = 1'b1;
        end else if (wait_cnt == TW'(DONE_TIMEOUT - 1)) begin
          timeout_err_n = 1'b1;
          go_idle       = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + TW'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    // An empty holding register at a sample costs a filler slot; a byte
    // captured on that same edge waits for the next slot.
    if (load_payload) begin
      frame_len_n = sat_inc8(frame_len);
      if (hold_valid) begin
        wh_din_n     = hold_data;
        din_last_n   = hold_last;
        hold_valid_n = 1'b0;
      end else begin
        wh_din_n   = 8'h00;
        din_last_n = 1'b0;
        underrun_n = 1'b1;
      end
    end

    if (go_idle) begin
      state_n      = ST_IDLE;
      wh_din_n     = 8'h00;
      din_last_n   = 1'b0;
      last_taken_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hold_data   <= 8'h00;
      hold_valid  <= 1'b0;
      hold_last   <= 1'b0;
      last_taken  <= 1'b0;
      din_last    <= 1'b0;
      wh_din      <= 8'h00;
      wh_ind      <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= 8'h00;
      underrun    <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      hold_data   <= hold_data_n;
      hold_valid  <= hold_valid_n;
      hold_last   <= hold_last_n;
      last_taken  <= last_taken_n;
      din_last    <= din_last_n;
      wh_din      <= wh_din_n;
      wh_ind      <= wh_ind_n;
      frame_done  <= frame_done_n;
      frame_len   <= frame_len_n;
      underrun    <= underrun_n;
      timeout_err <= timeout_err_n;
      wait_cnt    <= wait_cnt_n;
    end
  end

endmodule
